// File: rtl/operand_fetch_if.sv
// Decode-to-fetch and fetch-to-execute handshake bundle for operand_fetch.
// slave: the fetch stage itself. master: the upstream/downstream driver.
interface operand_fetch_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_rd_we;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_op1;
    logic [WIDTH-1:0]  out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_we;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with writeback forwarding, a busy
// scoreboard for RAW/WAW hazards, one-cycle output register and flush.

// Per-source hazard check and operand select.
module of_src #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic              busy_bit,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic [WIDTH-1:0]  rf_data,
    output logic              haz,
    output logic [WIDTH-1:0]  op
);
    logic nz;
    logic hit;

    assign nz  = (rs != '0);
    assign hit = wb_valid && (wb_addr == rs) && nz;
    assign haz = nz && busy_bit && !hit;

    always_comb begin
        op = rf_data;
        if (!nz)
            op = '0;
        else if (hit)
            op = wb_data;
    end
endmodule

module operand_fetch #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.slave    io,
    output logic [ADDR_W-1:0] rf_read_addr_1,
    output logic [ADDR_W-1:0] rf_read_addr_2,
    input  logic [WIDTH-1:0]  rf_data_1,
    input  logic [WIDTH-1:0]  rf_data_2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              flush,
    output logic [15:0]       stall_cnt
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]             busy;
    logic [NREG-1:0]             busy_nxt;
    logic [1:0][ADDR_W-1:0]      src_addr;
    logic [1:0][WIDTH-1:0]       src_rf;
    logic [1:0][WIDTH-1:0]       src_op;
    logic [1:0]                  src_haz;
    logic [1:0]                  src_busy;
    logic                        rd_nz;
    logic                        rd_hit;
    logic                        waw;
    logic                        hazard;
    logic                        accept;
    logic                        flush_drop;

    assign rf_read_addr_1 = io.in_rs1;
    assign rf_read_addr_2 = io.in_rs2;
    assign src_addr       = {io.in_rs2, io.in_rs1};
    assign src_rf         = {rf_data_2, rf_data_1};

    for (genvar g = 0; g < 2; g++) begin : g_src
        assign src_busy[g] = busy[src_addr[g]];
        of_src #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_src (
            .rs       (src_addr[g]),
            .busy_bit (src_busy[g]),
            .wb_valid (wb_valid),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .rf_data  (src_rf[g]),
            .haz      (src_haz[g]),
            .op       (src_op[g])
        );
    end

    // WAW: only one outstanding writer per register is tracked
    assign rd_nz  = (io.in_rd != '0);
    assign rd_hit = wb_valid && (wb_addr == io.in_rd) && rd_nz;
    assign waw    = io.in_rd_we && rd_nz && busy[io.in_rd] && !rd_hit;
    assign hazard = |src_haz || waw;

    assign io.in_ready = rst && (!io.out_valid || io.out_ready) && !hazard && !flush;
    assign accept      = io.in_valid && io.in_ready;
    assign flush_drop  = flush && io.out_valid;

    // Clears first, then set, so a same-cycle set on the same index wins
    always_comb begin
        busy_nxt = busy;
        if (wb_valid && wb_addr != '0)
            busy_nxt[wb_addr] = 1'b0;
        if (flush_drop && io.out_rd_we && io.out_rd != '0)
            busy_nxt[io.out_rd] = 1'b0;
        if (accept && io.in_rd_we && rd_nz)
            busy_nxt[io.in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            io.out_valid <= 1'b0;
            io.out_op1   <= '0;
            io.out_op2   <= '0;
            io.out_rd    <= '0;
            io.out_rd_we <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (accept) begin
                io.out_valid <= 1'b1;
                io.out_op1   <= src_op[0];
                io.out_op2   <= src_op[1];
                io.out_rd    <= io.in_rd;
                io.out_rd_we <= io.in_rd_we;
            end else if (flush_drop || (io.out_valid && io.out_ready)) begin
                io.out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (io.in_valid && hazard && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: fetch, RAW/WAW stalls, forwarding, x0,
// backpressure, flush, counter saturation and asynchronous reset.
module tb_operand_fetch;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] rf_read_addr_1, rf_read_addr_2;
    logic [WIDTH-1:0]  rf_data_1, rf_data_2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              flush;
    logic [15:0]       stall_cnt;
    logic [WIDTH-1:0]  rf_mem [32];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;

    operand_fetch_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    operand_fetch #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .io             (bus),
        .rf_read_addr_1 (rf_read_addr_1),
        .rf_read_addr_2 (rf_read_addr_2),
        .rf_data_1      (rf_data_1),
        .rf_data_2      (rf_data_2),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .flush          (flush),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    assign rf_data_1 = rf_mem[rf_read_addr_1];
    assign rf_data_2 = rf_mem[rf_read_addr_2];

    task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                         input logic we, input logic ordy);
        bus.in_valid  = v;
        bus.in_rs1    = ADDR_W'(rs1);
        bus.in_rs2    = ADDR_W'(rs2);
        bus.in_rd     = ADDR_W'(rd);
        bus.in_rd_we  = we;
        bus.out_ready = ordy;
    endtask

    task automatic set_wb(input logic v, input int a, input logic [WIDTH-1:0] d);
        wb_valid = v;
        wb_addr  = ADDR_W'(a);
        wb_data  = d;
    endtask

    task automatic test_reset;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        n_tests++; if (bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h0) begin n_fail++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.out_op1, bus.out_op2); end
        n_tests++; if (bus.out_rd !== 5'd0 || bus.out_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %0d/%0b want 0/0", bus.out_rd, bus.out_rd_we); end
        n_tests++; if (dut.busy !== 32'h0 || stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_busy_cnt: got %h/%h want 0/0", dut.busy, stall_cnt); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic;
        @(negedge clk); drive(1, 1, 2, 3, 1, 1); #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0b want 1", bus.in_ready); end
        n_tests++; if (rf_read_addr_1 !== 5'd1 || rf_read_addr_2 !== 5'd2) begin n_fail++; $display("FAIL basic_rf_addr: got %0d/%0d want 1/2", rf_read_addr_1, rf_read_addr_2); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'h11 || bus.out_op2 !== 32'h22) begin n_fail++; $display("FAIL basic_ops: got v=%0b %h/%h want 1 11/22", bus.out_valid, bus.out_op1, bus.out_op2); end
        n_tests++; if (bus.out_rd !== 5'd3 || bus.out_rd_we !== 1'b1 || dut.busy[3] !== 1'b1) begin n_fail++; $display("FAIL basic_rd_busy: got rd=%0d we=%0b busy=%0b want 3 1 1", bus.out_rd, bus.out_rd_we, dut.busy[3]); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1); set_wb(1, 3, 32'h33);
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0 || dut.busy[3] !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got v=%0b busy3=%0b want 0 0", bus.out_valid, dut.busy[3]); end
        @(negedge clk); set_wb(0, 0, 0);
    endtask

    task automatic test_raw;
        @(negedge clk); drive(1, 0, 0, 5, 1, 1);
        @(negedge clk); drive(1, 5, 0, 0, 0, 1); #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_in_ready: got %0b want 0", bus.in_ready); end
        @(posedge clk); #1; exp_stall++;
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall1: got %0d want %0d", stall_cnt, exp_stall); end
        @(posedge clk); #1; exp_stall++;
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall2: got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk); set_wb(1, 5, 32'hDEADBEEF); #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_fwd_ready: got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_op1 !== 32'hDEADBEEF || dut.busy[5] !== 1'b0) begin n_fail++; $display("FAIL raw_fwd: got %h busy5=%0b want deadbeef 0", bus.out_op1, dut.busy[5]); end
        n_tests++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall_hold: got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1); set_wb(0, 0, 0);
    endtask

    task automatic test_x0;
        @(negedge clk); drive(1, 0, 2, 0, 1, 1); set_wb(1, 0, 32'h1234);
        @(posedge clk); #1;
        n_tests++; if (bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h22) begin n_fail++; $display("FAIL x0_ops: got %h/%h want 0/22", bus.out_op1, bus.out_op2); end
        n_tests++; if (dut.busy !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h want 0", dut.busy); end
        @(negedge clk); drive(1, 0, 0, 0, 0, 1); set_wb(0, 0, 0); #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall: got %0b want 1", bus.in_ready); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk); drive(1, 1, 2, 7, 1, 0);
        @(negedge clk); drive(1, 3, 4, 8, 0, 0); #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'h11 || bus.out_op2 !== 32'h22 || bus.out_rd !== 5'd7) begin n_fail++; $display("FAIL bp_hold%0d: got v=%0b %h/%h rd=%0d want 1 11/22 7", i, bus.out_valid, bus.out_op1, bus.out_op2, bus.out_rd); end
        end
        @(negedge clk); drive(1, 1, 1, 7, 1, 1); #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %0b want 0", bus.in_ready); end
        @(posedge clk); #1; exp_stall++;
        n_tests++; if (bus.out_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL waw_drain: got v=%0b cnt=%0d want 0 %0d", bus.out_valid, stall_cnt, exp_stall); end
        @(negedge clk); set_wb(1, 7, 32'h77); #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (dut.busy[7] !== 1'b1 || bus.out_rd !== 5'd7 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL waw_set_wins: got busy7=%0b rd=%0d v=%0b want 1 7 1", dut.busy[7], bus.out_rd, bus.out_valid); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        n_tests++; if (dut.busy[7] !== 1'b0) begin n_fail++; $display("FAIL waw_clear: got %0b want 0", dut.busy[7]); end
        @(negedge clk); set_wb(0, 0, 0);
    endtask

    task automatic test_flush;
        @(negedge clk); drive(1, 1, 2, 9, 1, 0);
        @(posedge clk); #1;
        n_tests++; if (dut.busy[9] !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got busy9=%0b v=%0b want 1 1", dut.busy[9], bus.out_valid); end
        @(negedge clk); drive(1, 1, 0, 10, 1, 1); flush = 1'b1; #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0 || dut.busy[9] !== 1'b0 || dut.busy[10] !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got v=%0b b9=%0b b10=%0b want 0 0 0", bus.out_valid, dut.busy[9], dut.busy[10]); end
        @(negedge clk); drive(1, 9, 0, 0, 0, 1); flush = 1'b0; #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_rs9_ready: got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'h99) begin n_fail++; $display("FAIL flush_rs9_op: got v=%0b %h want 1 99", bus.out_valid, bus.out_op1); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
        @(negedge clk); flush = 1'b1; #1;
        n_tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got rdy=%0b v=%0b want 0 0", bus.in_ready, bus.out_valid); end
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic test_sat_reset;
        int n;
        @(negedge clk); drive(1, 1, 2, 12, 1, 0);
        @(negedge clk); drive(1, 12, 0, 0, 0, 0);
        n = 16'hFFFF - exp_stall;
        repeat (n) @(posedge clk);
        #1;
        n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        #1; rst = 1'b0; #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h0) begin n_fail++; $display("FAIL async_rst_out: got v=%0b %h/%h want 0 0/0", bus.out_valid, bus.out_op1, bus.out_op2); end
        n_tests++; if (bus.out_rd !== 5'd0 || bus.out_rd_we !== 1'b0 || dut.busy !== 32'h0 || stall_cnt !== 16'h0) begin n_fail++; $display("FAIL async_rst_state: got rd=%0d we=%0b busy=%h cnt=%h want 0", bus.out_rd, bus.out_rd_we, dut.busy, stall_cnt); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %0b want 0", bus.in_ready); end
        @(negedge clk); rst = 1'b1; drive(1, 12, 0, 0, 0, 1); #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_forgets: got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'hCC) begin n_fail++; $display("FAIL rst_issue: got v=%0b %h want 1 cc", bus.out_valid, bus.out_op1); end
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rf_mem[0] = 32'hFFFFFFFF;
        for (int i = 1; i < 32; i++) rf_mem[i] = 32'(i * 32'h11);
        drive(0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        flush = 1'b0;
        test_reset();
        test_basic();
        test_raw();
        test_x0();
        test_backpressure();
        test_flush();
        test_sat_reset();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
